// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised FIFO.
package fifo_pkg;

    localparam int DEF_WIDTH = 15;
    localparam int DEF_DEPTH = 8;

    // Memory address width for a given depth.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer/count width: one extra bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer bundle for param_fifo.
// Handshake: a write is taken on a posedge when wr_en=1 and full=0; a read is
// taken when rd_en=1 and empty=0, and its word appears on rd_data with
// rd_valid=1 in the following cycle. Requests made against full/empty are
// dropped and reported by a one-cycle overflow/underflow pulse.
interface param_fifo_if #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module fifo_ram #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Store the write word at the write address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO: pointers, occupancy, flags and error pulses around fifo_ram.
// Count and flags come from the registered pointers only.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 1
) (
    input logic         clk,
    input logic         rst,
    param_fifo_if.slave bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          rd_valid_q, overflow_q, underflow_q;
    logic [PW-1:0] count;
    logic          full, empty;
    logic          wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    assign count  = wptr_q - rptr_q;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    // Next pointer values: advance only on accepted requests.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) wptr_d = wptr_q + 1'b1;
        if (rd_acc) rptr_d = rptr_q + 1'b1;
    end

    // Pointers, read-valid and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= bus.wr_en && full;
            underflow_q <= bus.rd_en && empty;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (bus.wr_data),
        .re_i    (rd_acc),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.rd_data      = ram_rdata;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AFULL_C);
    assign bus.almost_empty = (count <= AEMPTY_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed scenarios plus a randomized run, all scored
// against a queue model of FIFO behaviour.
module tb_param_fifo;
    localparam int WIDTH = 15;
    localparam int DEPTH = 8;
    localparam int AFULL = DEPTH - 2;
    localparam int AEMPTY = 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFULL),
        .AEMPTY_LVL (AEMPTY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_rd_data;
    logic             exp_rd_valid;
    logic             exp_ovf;
    logic             exp_udf;

    task automatic model_reset();
        exp_q.delete();
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model across the edge, and
    // return 1 ns after the edge so outputs can be sampled.
    task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rd);
        int n;
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        @(posedge clk);
        n = exp_q.size();
        exp_ovf      = wr && (n == DEPTH);
        exp_udf      = rd && (n == 0);
        exp_rd_valid = rd && (n > 0);
        if (rd && n > 0) exp_rd_data = exp_q.pop_front();
        if (wr && n < DEPTH) exp_q.push_back(d);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got=%b want=1", bus.almost_empty); end
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", bus.full); end
        n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b want=0", bus.almost_full); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
        n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_errs got=%b%b want=00", bus.overflow, bus.underflow); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, WIDTH'(i), 1'b0);
            n_checks++; if (bus.count !== CW'(i)) begin n_fail++; $display("FAIL fill_count got=%0d want=%0d", bus.count, i); end
            n_checks++; if (bus.almost_full !== (i >= AFULL)) begin n_fail++; $display("FAIL fill_afull at=%0d got=%b", i, bus.almost_full); end
            n_checks++; if (bus.full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full at=%0d got=%b", i, bus.full); end
        end
        step(1'b1, 15'h7FFF, 1'b0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b want=1", bus.overflow); end
        n_checks++; if (bus.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count got=%0d want=%0d", bus.count, DEPTH); end
        step(1'b0, '0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got=%b want=0", bus.overflow); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid at=%0d got=%b", i, bus.rd_valid); end
            n_checks++; if (bus.rd_data !== WIDTH'(i)) begin n_fail++; $display("FAIL drain_data got=%h want=%h", bus.rd_data, WIDTH'(i)); end
            n_checks++; if (bus.empty !== (i == DEPTH)) begin n_fail++; $display("FAIL drain_empty at=%0d got=%b", i, bus.empty); end
            n_checks++; if (bus.almost_empty !== (DEPTH - i <= AEMPTY)) begin n_fail++; $display("FAIL drain_aempty at=%0d got=%b", i, bus.almost_empty); end
        end
        step(1'b0, '0, 1'b1);
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got=%b want=1", bus.underflow); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL udf_valid got=%b want=0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== WIDTH'(DEPTH)) begin n_fail++; $display("FAIL udf_hold got=%h want=%h", bus.rd_data, WIDTH'(DEPTH)); end
        step(1'b0, '0, 1'b0);
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_one_cycle got=%b want=0", bus.underflow); end
    endtask

    task automatic test_wrap();
        int plan[4] = '{5, 5, 8, 8};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < plan[p]; k++) begin
                if (p % 2 == 0) begin
                    step(1'b1, WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0);
                end else begin
                    step(1'b0, '0, 1'b1);
                    n_checks++; if (bus.rd_data !== exp_rd_data || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_data got=%h/%b want=%h/1", bus.rd_data, bus.rd_valid, exp_rd_data); end
                end
            end
        end
        n_checks++; if (bus.count !== CW'(0) || bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_count got=%0d want=0", bus.count); end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] d;
        for (int k = 0; k < 4; k++) step(1'b1, WIDTH'($urandom), 1'b0);
        d = WIDTH'($urandom);
        step(1'b1, d, 1'b1);
        n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL sim_mid_count got=%0d want=4", bus.count); end
        n_checks++; if (bus.rd_data !== exp_rd_data) begin n_fail++; $display("FAIL sim_mid_data got=%h want=%h", bus.rd_data, exp_rd_data); end
        for (int k = 0; k < 4; k++) step(1'b1, WIDTH'($urandom), 1'b0);
        step(1'b1, 15'h1234, 1'b1);
        n_checks++; if (bus.count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL sim_full_count got=%0d want=%0d", bus.count, DEPTH - 1); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_ovf got=%b want=1", bus.overflow); end
        n_checks++; if (bus.rd_data !== exp_rd_data || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL sim_full_data got=%h want=%h", bus.rd_data, exp_rd_data); end
        while (exp_q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            n_checks++; if (bus.rd_data !== exp_rd_data) begin n_fail++; $display("FAIL sim_drain_data got=%h want=%h", bus.rd_data, exp_rd_data); end
        end
        d = WIDTH'($urandom);
        step(1'b1, d, 1'b1);
        n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL sim_empty_count got=%0d want=1", bus.count); end
        n_checks++; if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL sim_empty_udf got=%b/%b want=1/0", bus.underflow, bus.rd_valid); end
        step(1'b0, '0, 1'b1);
        n_checks++; if (bus.rd_data !== d) begin n_fail++; $display("FAIL sim_empty_data got=%h want=%h", bus.rd_data, d); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            n_checks++;
            if (bus.count !== CW'(exp_q.size()) || bus.full !== (exp_q.size() == DEPTH) ||
                bus.empty !== (exp_q.size() == 0) || bus.almost_full !== (exp_q.size() >= AFULL) ||
                bus.almost_empty !== (exp_q.size() <= AEMPTY) || bus.rd_valid !== exp_rd_valid ||
                bus.rd_data !== exp_rd_data || bus.overflow !== exp_ovf || bus.underflow !== exp_udf) begin
                n_fail++;
                $display("FAIL rand cyc=%0d got cnt=%0d v=%b d=%h o=%b u=%b want cnt=%0d v=%b d=%h o=%b u=%b",
                         c, bus.count, bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow,
                         exp_q.size(), exp_rd_valid, exp_rd_data, exp_ovf, exp_udf);
            end
        end
        while (exp_q.size() > 0) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_midop();
        for (int k = 0; k < 5; k++) step(1'b1, WIDTH'($urandom), 1'b0);
        bus.rd_en = 1'b1;
        @(posedge clk);
        #2;
        bus.rd_en = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b want=0", bus.rd_valid); end
        n_checks++; if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_count got=%0d want=0", bus.count); end
        n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL mid_rst_data got=%h want=0", bus.rd_data); end
        n_checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags got=%b%b%b%b want=0000", bus.full, bus.almost_full, bus.overflow, bus.underflow); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step(1'b1, 15'h0ABC, 1'b0);
        step(1'b0, '0, 1'b1);
        n_checks++; if (bus.rd_data !== 15'h0ABC || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_after got=%h/%b want=0abc/1", bus.rd_data, bus.rd_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
